// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter: widths,
// default sizing, the buffered result entry and the write-port source select.
package rf_wb_arbiter_pkg;

    localparam int REG_ADDR_W       = 5;
    localparam int DATA_W           = 32;
    localparam int NUM_REGS         = 1 << REG_ADDR_W;
    localparam int FIFO_DEPTH_DEF   = 2;
    localparam int STARVE_LIMIT_DEF = 3;

    // One buffered multi-cycle result waiting for the write port.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

    // Which requester drives the register-file write port this cycle.
    typedef enum logic [1:0] {
        SRC_NONE  = 2'd0,
        SRC_PIPE  = 2'd1,
        SRC_BUF   = 2'd2,
        SRC_FORCE = 2'd3
    } wr_src_e;

    // Bits needed to index n entries; never less than one.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_wb_fifo.sv
// wb_fifo: synchronous FIFO of pending multi-cycle results. Writes and reads
// are both registered, so a push into an empty FIFO is visible at the head
// only from the following cycle. push is ignored when full, pop when empty.
module wb_fifo
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  wb_entry_t din,
    input  logic      pop,
    output wb_entry_t dout,
    output logic      full,
    output logic      empty
);

    localparam int PW = idx_w(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    wb_entry_t       mem_q [DEPTH];
    wb_entry_t       mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push_ok;
    logic            pop_ok;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    // Next pointers, occupancy and storage from the guarded push/pop.
    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer/occupancy registers; reset empties the FIFO, data is left stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array update.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares one register-file write port between the in-order
// pipeline writeback and buffered multi-cycle results, with a starvation
// counter that forces the buffer head through, and a pending-register
// scoreboard used upstream for hazard checks.
//
// Handshakes: a multi-cycle result transfers on a posedge where md_valid and
// md_ready are both 1 (md_ready depends only on registered state and rst).
// A pipeline request (wb_we with wb_rd != 0) is consumed on any posedge where
// wb_stall is 0; while wb_stall is 1 upstream holds wb_* unchanged.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0]     wb_wd,
    output logic                  wb_stall,
    input  logic                  md_valid,
    input  logic [REG_ADDR_W-1:0] md_rd,
    input  logic [DATA_W-1:0]     md_wd,
    output logic                  md_ready,
    input  logic                  iss_valid,
    input  logic [REG_ADDR_W-1:0] iss_rd,
    input  logic [REG_ADDR_W-1:0] chk_a1,
    input  logic [REG_ADDR_W-1:0] chk_a2,
    output logic                  busy1,
    output logic                  busy2,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_a3,
    output logic [DATA_W-1:0]     rf_wd
);

    localparam int SW = idx_w(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    logic [SW-1:0]       starve_q, starve_d;
    logic [NUM_REGS-1:0] pending_q, pending_d;

    wb_entry_t fifo_din;
    wb_entry_t fifo_head;
    logic      fifo_push;
    logic      fifo_pop;
    logic      fifo_full;
    logic      fifo_empty;
    logic      pipe_valid;
    wr_src_e   wr_src;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Write-port arbitration and result-buffer acceptance.
    always_comb begin
        pipe_valid = wb_we && (wb_rd != '0);
        wr_src     = SRC_NONE;
        if (!rst) begin
            if (!fifo_empty && (starve_q == LIMIT)) begin
                wr_src = SRC_FORCE;
            end else if (pipe_valid) begin
                wr_src = SRC_PIPE;
            end else if (!fifo_empty) begin
                wr_src = SRC_BUF;
            end
        end
        rf_we    = (wr_src != SRC_NONE);
        rf_a3    = (wr_src == SRC_PIPE) ? wb_rd : fifo_head.rd;
        rf_wd    = (wr_src == SRC_PIPE) ? wb_wd : fifo_head.data;
        wb_stall = (wr_src == SRC_FORCE) && pipe_valid;
        fifo_pop = (wr_src == SRC_FORCE) || (wr_src == SRC_BUF);

        // Results for x0 are acknowledged but never stored.
        md_ready      = !fifo_full && !rst;
        fifo_push     = md_valid && md_ready && (md_rd != '0);
        fifo_din.rd   = md_rd;
        fifo_din.data = md_wd;
    end

    // Starve counter and pending-register scoreboard next state.
    always_comb begin
        starve_d = starve_q;
        if (fifo_pop || fifo_empty) begin
            starve_d = '0;
        end else if ((wr_src == SRC_PIPE) && (starve_q != LIMIT)) begin
            starve_d = starve_q + 1'b1;
        end

        // Clear first so a same-cycle re-issue of the popped rd stays pending.
        pending_d = pending_q;
        if (fifo_pop) begin
            pending_d[fifo_head.rd] = 1'b0;
        end
        if (iss_valid && (iss_rd != '0)) begin
            pending_d[iss_rd] = 1'b1;
        end
    end

    // Hazard lookups for the two source operands; x0 is never busy.
    always_comb begin
        busy1 = (chk_a1 != '0) && pending_q[chk_a1];
        busy2 = (chk_a2 != '0) && pending_q[chk_a2];
    end

    // Counter and scoreboard registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q  <= '0;
            pending_q <= '0;
        end else begin
            starve_q  <= starve_d;
            pending_q <= pending_d;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios followed by random traffic,
// all compared against a queue-based reference model of the arbiter rules.
module tb_rf_wb_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_wd;
    logic        wb_stall;
    logic        md_valid;
    logic [4:0]  md_rd;
    logic [31:0] md_wd;
    logic        md_ready;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  chk_a1;
    logic [4:0]  chk_a2;
    logic        busy1;
    logic        busy2;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: buffered results in arrival order, pending regs.
    logic [36:0] mq[$];
    bit [31:0]   pend_m;
    int          starve_m;

    logic        exp_we, exp_stall, exp_ready, exp_b1, exp_b2, exp_pop;
    logic [4:0]  exp_a3;
    logic [31:0] exp_wd;

    rf_wb_arbiter #(
        .FIFO_DEPTH   (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_we     (wb_we),
        .wb_rd     (wb_rd),
        .wb_wd     (wb_wd),
        .wb_stall  (wb_stall),
        .md_valid  (md_valid),
        .md_rd     (md_rd),
        .md_wd     (md_wd),
        .md_ready  (md_ready),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .chk_a1    (chk_a1),
        .chk_a2    (chk_a2),
        .busy1     (busy1),
        .busy2     (busy2),
        .rf_we     (rf_we),
        .rf_a3     (rf_a3),
        .rf_wd     (rf_wd)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected combinational outputs for the current inputs and model state.
    task automatic model_eval();
        bit pv;
        pv        = wb_we && (wb_rd != 0);
        exp_we    = 0;
        exp_stall = 0;
        exp_pop   = 0;
        exp_a3    = 0;
        exp_wd    = 0;
        exp_ready = !rst && (mq.size() < DEPTH);
        if (!rst) begin
            if (mq.size() > 0 && starve_m == LIMIT) begin
                exp_we = 1; {exp_a3, exp_wd} = mq[0]; exp_stall = pv; exp_pop = 1;
            end else if (pv) begin
                exp_we = 1; exp_a3 = wb_rd; exp_wd = wb_wd;
            end else if (mq.size() > 0) begin
                exp_we = 1; {exp_a3, exp_wd} = mq[0]; exp_pop = 1;
            end
        end
        exp_b1 = (chk_a1 != 0) && pend_m[chk_a1];
        exp_b2 = (chk_a2 != 0) && pend_m[chk_a2];
    endtask

    // Model state change at the clock edge.
    task automatic model_update();
        bit          was_empty;
        logic [36:0] e;
        if (rst) begin
            mq.delete();
            pend_m   = '0;
            starve_m = 0;
            return;
        end
        was_empty = (mq.size() == 0);
        if (exp_pop) begin
            e = mq.pop_front();
            pend_m[e[36:32]] = 1'b0;
        end
        if (iss_valid && iss_rd != 0) pend_m[iss_rd] = 1'b1;
        if (md_valid && exp_ready && md_rd != 0) mq.push_back({md_rd, md_wd});
        if (exp_pop || was_empty) starve_m = 0;
        else if (exp_we && starve_m < LIMIT) starve_m = starve_m + 1;
    endtask

    task automatic check_now();
        #1;
        model_eval();
        chk("rf_we", rf_we, exp_we);
        if (exp_we) begin
            chk("rf_a3", rf_a3, exp_a3);
            chk("rf_wd", rf_wd, exp_wd);
        end
        chk("wb_stall", wb_stall, exp_stall);
        chk("md_ready", md_ready, exp_ready);
        chk("busy1", busy1, exp_b1);
        chk("busy2", busy2, exp_b2);
    endtask

    task automatic adv();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic cyc();
        check_now();
        adv();
    endtask

    task automatic idle_inputs();
        wb_we = 0; wb_rd = 0; wb_wd = 0;
        md_valid = 0; md_rd = 0; md_wd = 0;
        iss_valid = 0; iss_rd = 0;
        chk_a1 = 0; chk_a2 = 0;
    endtask

    initial begin
        bit hold;
        pend_m   = '0;
        starve_m = 0;
        rst      = 1;
        idle_inputs();
        @(negedge clk);

        // Reset: no writes, not ready while held.
        wb_we = 1; wb_rd = 6; wb_wd = 32'h55; md_valid = 1; md_rd = 3;
        check_now();
        chk("rst_rf_we", rf_we, 0);
        chk("rst_md_ready", md_ready, 0);
        adv();
        idle_inputs();
        cyc();
        rst = 0;
        check_now();
        chk("post_rst_ready", md_ready, 1);
        chk("post_rst_stall", wb_stall, 0);
        chk("post_rst_we", rf_we, 0);
        adv();

        // Pipeline write, and a zero-register request being a no-op.
        wb_we = 1; wb_rd = 5; wb_wd = 32'h1234;
        check_now();
        chk("pipe_we", rf_we, 1);
        chk("pipe_a3", rf_a3, 5);
        chk("pipe_wd", rf_wd, 32'h1234);
        adv();
        wb_rd = 0;
        check_now();
        chk("x0_we", rf_we, 0);
        adv();
        idle_inputs();

        // Buffer drain of {7,AAAA} after issue of rd 7.
        iss_valid = 1; iss_rd = 7;
        cyc();
        iss_valid = 0; md_valid = 1; md_rd = 7; md_wd = 32'hAAAA; chk_a1 = 7;
        check_now();
        chk("no_bypass_we", rf_we, 0);
        chk("pend7_set", busy1, 1);
        adv();
        md_valid = 0;
        check_now();
        chk("drain_a3", rf_a3, 7);
        chk("drain_wd", rf_wd, 32'hAAAA);
        adv();
        check_now();
        chk("pend7_clr", busy1, 0);
        adv();

        // Starvation: head {9,BEEF} forced through after three pipeline wins.
        wb_we = 1; wb_rd = 3; wb_wd = 32'h3333;
        md_valid = 1; md_rd = 9; md_wd = 32'hBEEF;
        cyc();
        md_valid = 0;
        for (int i = 0; i < 3; i++) begin
            check_now();
            chk("starve_pipe_a3", rf_a3, 3);
            chk("starve_pipe_stall", wb_stall, 0);
            adv();
        end
        check_now();
        chk("starve_force_a3", rf_a3, 9);
        chk("starve_force_stall", wb_stall, 1);
        adv();
        check_now();
        chk("starve_resume_a3", rf_a3, 3);
        adv();

        // Full buffer: 1,2 accepted, 4 held until space, drained in order.
        md_valid = 1; md_rd = 1; md_wd = 32'h11;
        cyc();
        md_rd = 2; md_wd = 32'h22;
        cyc();
        md_rd = 4; md_wd = 32'h44;
        check_now();
        chk("full_ready", md_ready, 0);
        adv();
        wb_we = 0;
        check_now();
        chk("full_pop1_a3", rf_a3, 1);
        chk("full_pop1_ready", md_ready, 0);
        adv();
        check_now();
        chk("full_pop2_a3", rf_a3, 2);
        chk("full_pop2_ready", md_ready, 1);
        adv();
        md_valid = 0;
        check_now();
        chk("full_pop4_a3", rf_a3, 4);
        adv();

        // Scoreboard: re-issue of rd 8 in the same cycle it pops stays busy.
        iss_valid = 1; iss_rd = 8;
        cyc();
        iss_valid = 0; md_valid = 1; md_rd = 8; md_wd = 32'h88;
        cyc();
        md_valid = 0; iss_valid = 1; iss_rd = 8;
        check_now();
        chk("sb_pop_a3", rf_a3, 8);
        adv();
        iss_valid = 0; chk_a1 = 8;
        check_now();
        chk("sb_busy1", busy1, 1);
        adv();
        chk_a1 = 0;
        check_now();
        chk("sb_x0_busy1", busy1, 0);
        adv();

        // Reset mid-operation with two buffered entries and rd 8 pending.
        wb_we = 1; wb_rd = 3; md_valid = 1; md_rd = 12; md_wd = 32'hC;
        cyc();
        md_rd = 13; md_wd = 32'hD;
        cyc();
        md_valid = 0; wb_we = 0; rst = 1;
        cyc();
        rst = 0; chk_a1 = 8; chk_a2 = 12;
        check_now();
        chk("rst_mid_ready", md_ready, 1);
        chk("rst_mid_busy1", busy1, 0);
        chk("rst_mid_we", rf_we, 0);
        adv();
        check_now();
        chk("rst_mid_we2", rf_we, 0);
        adv();

        // Random traffic with occasional resets; wb_* held while stalled.
        hold = 0;
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            if (!hold) begin
                wb_we = ($urandom_range(0, 2) != 0);
                wb_rd = 5'($urandom_range(0, 7));
                wb_wd = $urandom;
            end
            md_valid  = ($urandom_range(0, 1) == 1);
            md_rd     = 5'($urandom_range(0, 15));
            md_wd     = $urandom;
            iss_valid = ($urandom_range(0, 3) == 0);
            iss_rd    = 5'($urandom_range(0, 15));
            chk_a1    = 5'($urandom_range(0, 15));
            chk_a2    = 5'($urandom_range(0, 15));
            cyc();
            hold = exp_stall && !rst;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
